// File: rtl/ecc_mont_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : ecc_mont_result_collector
// Description : Collects the word-serial result stream of the Montgomery PE
//               array (LSW first, plus the final top carry), performs the
//               final conditional subtraction of p word-serially with borrow,
//               and hands the reduced value to the ECC arithmetic unit over a
//               valid/ready handshake.
// Ports       : clk, reset_n (sync, active-low)
//               start_in            - begin new collection / abort
//               word_valid, word_in - result word stream, LSW first
//               carry_in            - top carry, sampled with the last word
//               p_in                - prime, stable until result handshake
//               busy                - high in COLLECT or SUB (registered)
//               res_valid/res_ready - result handshake, res_out < p
//               err_out             - pulse on a word outside COLLECT
// Notes       : NUM_WORDS must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_mont_result_collector #(
  parameter int RADIX     = 32,
  parameter int NUM_WORDS = 12,
  parameter int REG_SIZE  = RADIX * NUM_WORDS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_in,
  input  logic                word_valid,
  input  logic [RADIX-1:0]    word_in,
  input  logic                carry_in,
  input  logic [REG_SIZE-1:0] p_in,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [REG_SIZE-1:0] res_out,
  output logic                err_out
);

  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_SUB     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   err_d;

  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             carry_q;
  logic [RADIX-1:0] buf_q  [NUM_WORDS];
  // Only the lower NUM_WORDS-1 difference words need storage; the top word
  // is taken straight from the subtractor on the final SUB cycle.
  logic [RADIX-1:0] diff_q [NUM_WORDS-1];

  logic [REG_SIZE-1:0] buf_full;
  logic [REG_SIZE-1:0] diff_full;
  logic [RADIX-1:0]    buf_word;
  logic [RADIX-1:0]    p_word;
  logic [RADIX:0]      sub_full;
  logic [RADIX-1:0]    sub_word;
  logic                sub_borrow;
  logic                cnt_last;

  assign cnt_last = (cnt == LAST_IDX);

  // Word-serial subtractor: {bout, diff} = buf_i - p_i - borrow.
  always_comb begin
    buf_full = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      buf_full[i*RADIX +: RADIX] = buf_q[i];
    end
    buf_word   = buf_full[int'(cnt)*RADIX +: RADIX];
    p_word     = p_in[int'(cnt)*RADIX +: RADIX];
    sub_full   = {1'b0, buf_word} - {1'b0, p_word} - {{RADIX{1'b0}}, borrow};
    sub_word   = sub_full[RADIX-1:0];
    sub_borrow = sub_full[RADIX];
    diff_full  = '0;
    for (int i = 0; i < NUM_WORDS - 1; i++) begin
      diff_full[i*RADIX +: RADIX] = diff_q[i];
    end
    diff_full[(NUM_WORDS-1)*RADIX +: RADIX] = sub_word;
  end

  // Next-state and stray-word detection.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (start_in) begin
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (word_valid) err_d = 1'b1;
        end
        S_COLLECT: begin
          if (word_valid && cnt_last) state_d = S_SUB;
        end
        S_SUB: begin
          if (word_valid) err_d = 1'b1;
          if (cnt_last) state_d = S_DONE;
        end
        S_DONE: begin
          if (word_valid) err_d = 1'b1;
          if (res_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt       <= '0;
      borrow    <= 1'b0;
      carry_q   <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_out   <= '0;
      err_out   <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) buf_q[i] <= '0;
      for (int i = 0; i < NUM_WORDS - 1; i++) diff_q[i] <= '0;
    end else begin
      state_q <= state_d;
      err_out <= err_d;
      busy    <= (state_d == S_COLLECT) || (state_d == S_SUB);
      if (start_in) begin
        cnt       <= '0;
        borrow    <= 1'b0;
        res_valid <= 1'b0;
      end else begin
        case (state_q)
          S_COLLECT: begin
            if (word_valid) begin
              for (int i = 0; i < NUM_WORDS; i++) begin
                if (cnt == CNT_W'(i)) buf_q[i] <= word_in;
              end
              if (cnt_last) begin
                carry_q <= carry_in;
                cnt     <= '0;
                borrow  <= 1'b0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          S_SUB: begin
            for (int i = 0; i < NUM_WORDS - 1; i++) begin
              if (cnt == CNT_W'(i)) diff_q[i] <= sub_word;
            end
            borrow <= sub_borrow;
            if (cnt_last) begin
              // A set top carry means the true value exceeds 2^REG_SIZE, so
              // it is >= p even though the truncated subtraction borrows.
              res_out   <= (carry_q || !sub_borrow) ? diff_full : buf_full;
              res_valid <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DONE: begin
            if (res_ready) res_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
